// File: rtl/rv_mdu_radix_pkg.sv
// ============================================================================
//  Module   : rv_mdu_radix_pkg
//  Purpose  : Shared types and constants for the radix multiply/divide unit:
//             FSM state encoding, RISC-V M funct3 op codes, operand
//             signedness helpers.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_mdu_radix_pkg;

    // Sequencer states of the multiply/divide unit
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } mdu_state_t;

    // RISC-V M extension funct3 encodings
    localparam logic [2:0] c_F3_MUL    = 3'b000;
    localparam logic [2:0] c_F3_MULH   = 3'b001;
    localparam logic [2:0] c_F3_MULHSU = 3'b010;
    localparam logic [2:0] c_F3_MULHU  = 3'b011;
    localparam logic [2:0] c_F3_DIV    = 3'b100;
    localparam logic [2:0] c_F3_DIVU   = 3'b101;
    localparam logic [2:0] c_F3_REM    = 3'b110;
    localparam logic [2:0] c_F3_REMU   = 3'b111;

    // rs1 is treated as two's complement for these ops
    function automatic logic op1_is_signed(input logic [2:0] f3);
        return (f3 == c_F3_MULH) || (f3 == c_F3_MULHSU) ||
               (f3 == c_F3_DIV)  || (f3 == c_F3_REM);
    endfunction

    // rs2 is treated as two's complement for these ops (MULHSU: rs2 unsigned)
    function automatic logic op2_is_signed(input logic [2:0] f3);
        return (f3 == c_F3_MULH) || (f3 == c_F3_DIV) || (f3 == c_F3_REM);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rv_mdu_step.sv
// ============================================================================
//  Module   : rv_mdu_step
//  Purpose  : Combinational single-iteration datapath of the MDU. Multiply
//             retires MUL_STEP_BITS multiplier bits into the {hi,lo} product
//             register pair; divide performs one radix-2 restoring step with
//             hi = partial remainder and lo = dividend/quotient shifter.
//  Config   : RV_MDU_DIV_EN - when undefined the restoring divider is not
//             built and the step always performs a multiply iteration.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_mdu_step #(
    parameter int XLEN          = 32,
    parameter int MUL_STEP_BITS = 2
) (
    input  logic            i_div,
    input  logic [XLEN-1:0] i_hi,
    input  logic [XLEN-1:0] i_lo,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);

    localparam int c_sum_w = XLEN + MUL_STEP_BITS;

    logic [c_sum_w-1:0] w_sum;
    logic [XLEN-1:0]    w_mul_hi;
    logic [XLEN-1:0]    w_mul_lo;

    // Accumulate one partial product per retired multiplier bit; the upper
    // half never exceeds the multiplicand, so c_sum_w bits cannot overflow
    always_comb begin
        w_sum = {{MUL_STEP_BITS{1'b0}}, i_hi};
        for (int i = 0; i < MUL_STEP_BITS; i++) begin
            if (i_lo[i]) begin
                w_sum = w_sum + (c_sum_w'(i_b) << i);
            end
        end
    end

    // Shift the whole {sum, lo} product right by the retired bit count
    assign w_mul_hi = w_sum[c_sum_w-1:MUL_STEP_BITS];
    assign w_mul_lo = {w_sum[MUL_STEP_BITS-1:0], i_lo[XLEN-1:MUL_STEP_BITS]};

`ifdef RV_MDU_DIV_EN
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_trial;
    logic            w_qbit;
    logic [XLEN-1:0] w_div_hi;
    logic [XLEN-1:0] w_div_lo;

    // Restoring step: try subtracting the divisor from the shifted remainder
    always_comb begin
        w_shift  = {i_hi, i_lo[XLEN-1]};
        w_trial  = w_shift - {1'b0, i_b};
        w_qbit   = ~w_trial[XLEN];
        w_div_hi = w_qbit ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
        w_div_lo = {i_lo[XLEN-2:0], w_qbit};
    end

    assign o_hi = i_div ? w_div_hi : w_mul_hi;
    assign o_lo = i_div ? w_div_lo : w_mul_lo;
`else
    logic w_unused_div;
    assign w_unused_div = i_div;
    assign o_hi = w_mul_hi;
    assign o_lo = w_mul_lo;
`endif

endmodule

`default_nettype wire

// File: rtl/rv_mdu_radix.sv
// ============================================================================
//  Module   : rv_mdu_radix
//  Purpose  : Iterative RISC-V M-extension unit. Shift-add multiply retiring
//             MUL_STEP_BITS bits per cycle, radix-2 restoring divide, sign
//             fix-up cycle, valid/ready request and result handshakes.
//  Config   : RV_MDU_DIV_EN - defined: full M set. Undefined: divide/rem ops
//             are accepted and complete after one cycle with result 0.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_mdu_radix #(
    parameter int XLEN          = 32,
    parameter int MUL_STEP_BITS = 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    input  logic [4:0]      i_rd,
    output logic            o_valid,
    input  logic            i_res_ready,
    output logic [XLEN-1:0] o_result,
    output logic [4:0]      o_rd
);

    import rv_mdu_radix_pkg::*;

    localparam int c_cnt_w = $clog2(XLEN);
    localparam logic [c_cnt_w-1:0] c_mul_last = c_cnt_w'(XLEN / MUL_STEP_BITS - 1);
    localparam logic [c_cnt_w-1:0] c_div_last = c_cnt_w'(XLEN - 1);

    mdu_state_t         r_state;
    mdu_state_t         w_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [XLEN-1:0]    r_hi;
    logic [XLEN-1:0]    r_lo;
    logic [XLEN-1:0]    r_b;
    logic [XLEN-1:0]    r_result;
    logic [2:0]         r_funct3;
    logic [4:0]         r_rd;
    logic               r_neg;

    logic               w_accept;
    logic               w_special;
    logic [XLEN-1:0]    w_special_res;
    logic               w_op1_sgn;
    logic               w_op2_sgn;
    logic [XLEN-1:0]    w_abs1;
    logic [XLEN-1:0]    w_abs2;
    logic               w_last;
    logic [XLEN-1:0]    w_step_hi;
    logic [XLEN-1:0]    w_step_lo;
    logic [2*XLEN-1:0]  w_prod;
    logic [XLEN-1:0]    w_fix_res;

    // Operand magnitudes and signs for the requested op
    assign w_op1_sgn = op1_is_signed(i_funct3) & i_op1[XLEN-1];
    assign w_op2_sgn = op2_is_signed(i_funct3) & i_op2[XLEN-1];
    assign w_abs1    = w_op1_sgn ? -i_op1 : i_op1;
    assign w_abs2    = w_op2_sgn ? -i_op2 : i_op2;
    assign w_accept  = (r_state == IDLE) && i_valid && !i_flush;
    assign w_last    = (r_cnt == (r_funct3[2] ? c_div_last : c_mul_last));

`ifdef RV_MDU_DIV_EN
    localparam logic [XLEN-1:0] c_most_neg = {1'b1, {(XLEN-1){1'b0}}};
    logic r_rem_neg;

    // Divide-by-zero and signed-overflow results bypass the iteration
    always_comb begin
        w_special     = 1'b0;
        w_special_res = '0;
        if (i_funct3[2]) begin
            if (i_op2 == '0) begin
                w_special     = 1'b1;
                w_special_res = i_funct3[1] ? i_op1 : '1;
            end else if (!i_funct3[0] && (i_op1 == c_most_neg) && (i_op2 == '1)) begin
                w_special     = 1'b1;
                w_special_res = i_funct3[1] ? '0 : i_op1;
            end
        end
    end
`else
    // Without a divider every divide/rem op completes at once with zero
    always_comb begin
        w_special     = i_funct3[2];
        w_special_res = '0;
    end
`endif

    rv_mdu_step #(
        .XLEN          (XLEN),
        .MUL_STEP_BITS (MUL_STEP_BITS)
    ) u_step (
        .i_div (r_funct3[2]),
        .i_hi  (r_hi),
        .i_lo  (r_lo),
        .i_b   (r_b),
        .o_hi  (w_step_hi),
        .o_lo  (w_step_lo)
    );

    // Apply result signs and select the architectural result
    always_comb begin
        w_prod    = {r_hi, r_lo};
        w_fix_res = '0;
        if (r_neg) begin
            w_prod = -w_prod;
        end
        case (r_funct3)
            c_F3_MUL:                          w_fix_res = w_prod[XLEN-1:0];
            c_F3_MULH, c_F3_MULHSU, c_F3_MULHU: w_fix_res = w_prod[2*XLEN-1:XLEN];
`ifdef RV_MDU_DIV_EN
            c_F3_DIV, c_F3_DIVU:               w_fix_res = r_neg ? -r_lo : r_lo;
            c_F3_REM, c_F3_REMU:               w_fix_res = r_rem_neg ? -r_hi : r_hi;
`endif
            default:                           w_fix_res = '0;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs; flush returns to IDLE from anywhere
    always_comb begin
        w_next  = r_state;
        o_ready = 1'b0;
        o_valid = 1'b0;
        case (r_state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    w_next = w_special ? DONE : CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_next = FIXUP;
                end
            end
            FIXUP: begin
                w_next = DONE;
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_res_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
        if (i_flush) begin
            w_next = IDLE;
        end
    end

    // Operand capture, iteration registers and result register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_funct3 <= '0;
            r_rd     <= '0;
            r_neg    <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_funct3 <= i_funct3;
            r_rd     <= i_rd;
            r_neg    <= w_op1_sgn ^ w_op2_sgn;
            r_hi     <= '0;
            // Divide shifts the dividend through lo; multiply shifts the multiplier
            r_lo     <= i_funct3[2] ? w_abs1 : w_abs2;
            r_b      <= i_funct3[2] ? w_abs2 : w_abs1;
            if (w_special) begin
                r_result <= w_special_res;
            end
        end else if ((r_state == CALC) && !i_flush) begin
            r_hi  <= w_step_hi;
            r_lo  <= w_step_lo;
            r_cnt <= r_cnt + 1'b1;
        end else if ((r_state == FIXUP) && !i_flush) begin
            r_result <= w_fix_res;
        end
    end

`ifdef RV_MDU_DIV_EN
    // Remainder takes the dividend's sign
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rem_neg <= 1'b0;
        end else if (w_accept) begin
            r_rem_neg <= w_op1_sgn;
        end
    end
`endif

    assign o_result = r_result;
    assign o_rd     = r_rd;

endmodule

`default_nettype wire

// File: tb/tb_rv_mdu_radix.sv
// ============================================================================
//  Module   : tb_rv_mdu_radix
//  Purpose  : Self-checking bench for rv_mdu_radix (XLEN=32, MUL_STEP_BITS=2)
//             with an arithmetic reference model. Expected divide results
//             follow RV_MDU_DIV_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_mdu_radix;

    localparam int XLEN     = 32;
    localparam int STEP     = 2;
    localparam int c_mul_lat = XLEN / STEP + 2;
    localparam int c_div_lat = XLEN + 2;

    logic            i_clk = 1'b0;
    logic            i_reset;
    logic            i_flush;
    logic            i_valid;
    logic            o_ready;
    logic [2:0]      i_funct3;
    logic [XLEN-1:0] i_op1;
    logic [XLEN-1:0] i_op2;
    logic [4:0]      i_rd;
    logic            o_valid;
    logic            i_res_ready;
    logic [XLEN-1:0] o_result;
    logic [4:0]      o_rd;

    int n_checks = 0;
    int n_errors = 0;

    rv_mdu_radix #(.XLEN(XLEN), .MUL_STEP_BITS(STEP)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_flush     (i_flush),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_funct3    (i_funct3),
        .i_op1       (i_op1),
        .i_op2       (i_op2),
        .i_rd        (i_rd),
        .o_valid     (o_valid),
        .i_res_ready (i_res_ready),
        .o_result    (o_result),
        .o_rd        (o_rd)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference result from the RISC-V M definitions using wide arithmetic
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ub;
        logic [63:0]        ua, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            3'b000: begin p = sa * sb; return p[31:0];  end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
`ifdef RV_MDU_DIV_EN
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'b101: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
`else
            default: return 32'd0;
`endif
        endcase
    endfunction

    // Expected cycles from accept edge to first edge with o_valid high
    function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return c_mul_lat;
`ifdef RV_MDU_DIV_EN
        if (b == 0) return 1;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return c_div_lat;
`else
        return 1;
`endif
    endfunction

    // Wait (bounded) for o_valid after an accept edge; returns edge count
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!o_valid && lat < 200) begin
            @(posedge i_clk); #1;
            lat++;
        end
    endtask

    // Issue one op (called 1 time unit after a rising edge), check it, consume it
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, output logic [31:0] res);
        int lat;
        i_valid = 1'b1; i_funct3 = f; i_op1 = a; i_op2 = b; i_rd = rd;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        wait_valid(lat);
        res = o_result;
        check({tag, "_lat"}, 64'(lat), 64'(model_lat(f, a, b)));
        check({tag, "_res"}, 64'(o_result), 64'(model(f, a, b)));
        check({tag, "_rd"},  64'(o_rd), 64'(rd));
        @(posedge i_clk); #1;
        check({tag, "_idle"}, 64'(o_ready), 64'd1);
    endtask

    function automatic logic [31:0] rnd_op();
        logic [31:0] corners [5];
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 20));
        return $urandom;
    endfunction

    initial begin
        logic [31:0] res;
        logic [31:0] exp_hold;
        int          lat;
        int          seen;

        i_reset = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_funct3 = '0;
        i_op1 = '0; i_op2 = '0; i_rd = '0; i_res_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_valid",  64'(o_valid),  64'd0);
        check("rst_result", 64'(o_result), 64'd0);
        check("rst_rd",     64'(o_rd),     64'd0);
        check("rst_ready",  64'(o_ready),  64'd1);
        i_reset = 1'b0;
        @(posedge i_clk); #1;

        // Directed multiply vectors
        run_op("mul7", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd1, res);
        check("mul7_lit", 64'(res), 64'hFFFF_FFEB);
        run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, res);
        check("mulhu_lit", 64'(res), 64'hFFFF_FFFE);
        run_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd3, res);
        check("mulh_lit", 64'(res), 64'h4000_0000);
        run_op("mul67", 3'b000, 32'd6, 32'd7, 5'd4, res);
        check("mul67_lit", 64'(res), 64'd42);

        // Directed divide vectors, including zero divisor and overflow
        run_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5, res);
        run_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, res);
        run_op("divu", 3'b101, 32'd100, 32'd7, 5'd7, res);
        run_op("remu", 3'b111, 32'd100, 32'd7, 5'd8, res);
        run_op("divu0", 3'b101, 32'd5, 32'd0, 5'd9, res);
        run_op("rem0", 3'b110, 32'd5, 32'd0, 5'd10, res);
        run_op("divov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, res);
        run_op("remov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, res);

        // Flush five cycles into a multiply
        i_valid = 1'b1; i_funct3 = 3'b000; i_op1 = 32'd123; i_op2 = 32'd456; i_rd = 5'd13;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        seen = 0;
        repeat (4) begin
            @(posedge i_clk); #1;
            if (o_valid) seen++;
        end
        i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        check("flush_ready", 64'(o_ready), 64'd1);
        repeat (25) begin
            if (o_valid) seen++;
            @(posedge i_clk); #1;
        end
        check("flush_novalid", 64'(seen), 64'd0);
        run_op("postflush", 3'b101, 32'd9, 32'd3, 5'd21, res);

        // Flush overrides a same-cycle accept
        i_valid = 1'b1; i_flush = 1'b1; i_funct3 = 3'b101; i_op1 = 32'd9; i_op2 = 32'd0; i_rd = 5'd22;
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_flush = 1'b0;
        check("flushacc_ready", 64'(o_ready), 64'd1);
        check("flushacc_valid", 64'(o_valid), 64'd0);

        // Result back-pressure: DONE holds outputs and refuses new requests
        i_res_ready = 1'b0;
        i_valid = 1'b1; i_funct3 = 3'b011; i_op1 = 32'hDEAD_BEEF; i_op2 = 32'h1234_5678; i_rd = 5'd17;
        exp_hold = model(3'b011, 32'hDEAD_BEEF, 32'h1234_5678);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        wait_valid(lat);
        check("bp_lat", 64'(lat), 64'(c_mul_lat));
        i_valid = 1'b1; i_funct3 = 3'b000; i_op1 = 32'd1; i_op2 = 32'd1; i_rd = 5'd30;
        repeat (3) begin
            @(posedge i_clk); #1;
            check("bp_valid",  64'(o_valid),  64'd1);
            check("bp_result", 64'(o_result), 64'(exp_hold));
            check("bp_rd",     64'(o_rd),     64'd17);
            check("bp_ready",  64'(o_ready),  64'd0);
        end
        i_valid = 1'b0; i_res_ready = 1'b1;
        @(posedge i_clk); #1;
        check("bp_release_ready", 64'(o_ready), 64'd1);
        check("bp_release_valid", 64'(o_valid), 64'd0);

        // Reset in the middle of a calculation discards it
        i_valid = 1'b1; i_funct3 = 3'b001; i_op1 = 32'h1357_9BDF; i_op2 = 32'h2468_ACE0; i_rd = 5'd25;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (6) @(posedge i_clk);
        #1;
        i_reset = 1'b1; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_reset = 1'b0; i_valid = 1'b0;
        check("midrst_valid",  64'(o_valid),  64'd0);
        check("midrst_result", 64'(o_result), 64'd0);
        check("midrst_rd",     64'(o_rd),     64'd0);
        check("midrst_ready",  64'(o_ready),  64'd1);
        seen = 0;
        repeat (25) begin
            @(posedge i_clk); #1;
            if (o_valid) seen++;
        end
        check("midrst_novalid", 64'(seen), 64'd0);

        // Randomized ops against the reference model
        for (int n = 0; n < 150; n++) begin
            run_op("rand", 3'($urandom_range(0, 7)), rnd_op(), rnd_op(), 5'($urandom), res);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rv_mdu_radix.md
RV_MDU_RADIX -- requirements
Module: rv_mdu_radix

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; legal values 32 or 64.
REQ-002 SHALL have parameter MUL_STEP_BITS, default 2, multiplier bits retired per cycle; legal values 1, 2, 4; must divide XLEN.
REQ-003 SHALL have port i_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_flush  input  1  abort the in-flight operation.
REQ-006 SHALL have port i_valid  input  1  request present.
REQ-007 SHALL have port o_ready  output  1  request accepted when i_valid and o_ready are both high.
REQ-008 SHALL have port i_funct3  input  3  RISC-V M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-009 SHALL have ports i_op1, i_op2  input  XLEN  rs1, rs2 operands.
REQ-010 SHALL have port i_rd  input  5  destination tag, returned unchanged.
REQ-011 SHALL have port o_valid  output  1  result present.
REQ-012 SHALL have port i_res_ready  input  1  consumer takes result when o_valid and i_res_ready are both high.
REQ-013 SHALL have port o_result  output  XLEN  selected result.
REQ-014 SHALL have port o_rd  output  5  tag of the result.

Function
REQ-015 SHALL implement states IDLE, CALC, FIXUP, DONE; o_ready = (state == IDLE).
REQ-016 IDLE->CALC on accept for normal ops; IDLE->DONE on accept for the special division cases (REQ-021, REQ-022).
REQ-017 On accept SHALL latch funct3 and rd, plus absolute operand values and result sign according to op signedness (MULHSU: op1 signed, op2 unsigned).
REQ-018 CALC SHALL last XLEN/MUL_STEP_BITS cycles for multiply and XLEN cycles for divide, counted by an internal counter cleared on accept.
REQ-019 Multiply SHALL be shift-add on the magnitudes into a 2*XLEN product; divide SHALL be radix-2 restoring, one quotient bit per cycle.
REQ-020 FIXUP (1 cycle) SHALL negate quotient/product by result sign, give remainder the dividend's sign, and select low half (MUL), high half (MULH*), quotient, or remainder.
REQ-021 Divide by zero: quotient all ones, remainder = op1, no CALC.
REQ-022 Signed overflow (DIV/REM, op1 = most-negative, op2 = -1): quotient = op1, remainder = 0, no CALC.
REQ-023 Latency from accept edge to first o_valid edge: mul XLEN/MUL_STEP_BITS+2 cycles, div XLEN+2 cycles, special cases 1 cycle.
REQ-024 DONE SHALL hold o_valid, o_result, o_rd stable until i_res_ready; DONE->IDLE on handshake; no new accept in the same cycle.
REQ-025 i_flush SHALL force IDLE on the next edge from any state, with no o_valid pulse; i_flush overrides a same-cycle accept or result handshake.
REQ-026 o_result and o_rd are don't-care while o_valid is low.

Reset
REQ-027 While i_reset is high at an edge: state IDLE, counter 0, o_valid 0, o_result 0, o_rd 0; reset dominates i_flush and i_valid.
REQ-028 Reset mid-CALC SHALL discard the operation; o_ready is 1 on the cycle after reset deasserts.

Configuration
REQ-029 Macro RV_MDU_DIV_EN defined: full M set as above.
REQ-030 Macro RV_MDU_DIV_EN undefined: no divider datapath synthesised; funct3[2]=1 ops are accepted, reach DONE after 1 cycle with o_result = 0; multiply behaviour unchanged.

Structure
REQ-031 State enum mdu_state_t and funct3 op constants SHALL be placed in the shared rv_structs.vh/rv_defines.vh definitions.
REQ-032 One sub-module rv_mdu_step SHALL hold the combinational single-iteration datapath (MUL_STEP_BITS partial products or one restoring subtract); sequencing stays in rv_mdu_radix.

Verification (XLEN=32, MUL_STEP_BITS=2, RV_MDU_DIV_EN defined unless noted)
REQ-033 MUL 7 x 0xFFFFFFFD -> 0xFFFFFFEB, o_valid 18 cycles after accept; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH 0x80000000 x 0x80000000 -> 0x40000000.
REQ-034 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF, each 34 cycles; DIVU 100 / 7 -> 14 and REMU -> 2.
REQ-035 DIVU 5 / 0 -> 0xFFFFFFFF, REM 5 / 0 -> 5, DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM same operands -> 0; each 1-cycle latency.
REQ-036 Flush 5 cycles into a MUL -> no o_valid, o_ready high next cycle; following DIVU 9/3 -> 3 with the new rd.
REQ-037 i_res_ready low for 3 cycles in DONE -> o_valid, o_result, o_rd constant and o_ready low; release -> IDLE next edge.
REQ-038 RV_MDU_DIV_EN undefined: DIVU 9/3 -> 0 after 1 cycle; MUL 6 x 7 -> 42 after 18 cycles.
